// File: rtl/panel_buttons_if.sv
// rtl/panel_buttons_if.sv - raw button inputs and navigation pulse outputs of the front panel
interface panel_buttons_if;
  logic btn_left;
  logic btn_right;
  logic btn_up;
  logic btn_down;
  logic left;
  logic right;
  logic up;
  logic down;

  modport master (
    output btn_left, btn_right, btn_up, btn_down,
    input  left, right, up, down
  );

  modport slave (
    input  btn_left, btn_right, btn_up, btn_down,
    output left, right, up, down
  );
endinterface

// File: rtl/panel_buttons.sv
// rtl/panel_buttons.sv - four independent sync/debounce/pulse channels for the panel buttons
// Optional auto-repeat (IDLE/HELD/REPEAT) enabled by defining AUTO_REPEAT_EN.
module panel_buttons #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 2500000
) (
  input logic            clk,
  input logic            reset,
  panel_buttons_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;
`else
  typedef enum logic {IDLE, HELD} state_t;
`endif

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 16777215 ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > 16777215 ||
      REPEAT_RATE < 1 || REPEAT_RATE > 16777215) begin : g_param_check
    $error("panel_buttons: timing parameter out of range 1..2^24-1");
  end

  logic [3:0] raw;
  logic [3:0] pulse;

  assign raw       = {bus.btn_down, bus.btn_up, bus.btn_right, bus.btn_left};
  assign bus.left  = pulse[0];
  assign bus.right = pulse[1];
  assign bus.up    = pulse[2];
  assign bus.down  = pulse[3];

  for (genvar g = 0; g < 4; g++) begin : g_ch
    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    state_t        state_q, state_d;
    logic          pulse_q, pulse_d;
`ifdef AUTO_REPEAT_EN
    logic [RW-1:0] rpt_q, rpt_d;
`endif

    // Counter only runs while the synchronized sample disagrees with the level.
    always_comb begin
      level_d  = level_q;
      db_cnt_d = '0;
      if (sync2_q != level_q) begin
        if (db_cnt_q >= DW'(DEBOUNCE_CYCLES - 1)) begin
          level_d = ~level_q;
        end else if (db_cnt_q != {DW{1'b1}}) begin
          db_cnt_d = db_cnt_q + 1'b1;
        end else begin
          db_cnt_d = db_cnt_q;
        end
      end
    end

    // A low level forces IDLE in every state, so IDLE with level high is a fresh press.
    always_comb begin
      state_d = state_q;
      pulse_d = 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_d   = rpt_q;
`endif
      if (!level_q) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            state_d = HELD;
            pulse_d = 1'b1;
`ifdef AUTO_REPEAT_EN
            rpt_d   = RW'(REPEAT_DELAY - 1);
`endif
          end
`ifdef AUTO_REPEAT_EN
          HELD, REPEAT: begin
            if (rpt_q == '0) begin
              state_d = REPEAT;
              pulse_d = 1'b1;
              rpt_d   = RW'(REPEAT_RATE - 1);
            end else begin
              rpt_d = rpt_q - 1'b1;
            end
          end
`else
          HELD: state_d = HELD;
`endif
          default: state_d = IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        level_q  <= 1'b0;
        db_cnt_q <= '0;
        state_q  <= IDLE;
        pulse_q  <= 1'b0;
`ifdef AUTO_REPEAT_EN
        rpt_q    <= '0;
`endif
      end else begin
        sync1_q  <= raw[g];
        sync2_q  <= sync1_q;
        level_q  <= level_d;
        db_cnt_q <= db_cnt_d;
        state_q  <= state_d;
        pulse_q  <= pulse_d;
`ifdef AUTO_REPEAT_EN
        rpt_q    <= rpt_d;
`endif
      end
    end

    assign pulse[g] = pulse_q;
  end

endmodule

// File: tb/tb_panel_buttons.sv
// tb/tb_panel_buttons.sv - directed-vector bench for panel_buttons (either AUTO_REPEAT_EN build)
module tb_panel_buttons;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  panel_buttons_if bus ();

  panel_buttons #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.down, bus.up, bus.right, bus.left};
  endfunction

  task automatic set_btn(input logic [3:0] b);
    bus.btn_left  = b[0];
    bus.btn_right = b[1];
    bus.btn_up    = b[2];
    bus.btn_down  = b[3];
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_btn(4'b0000);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge; cycle k is the k-th posedge with the stimulus applied.
  // bounce_until: cycles 1..bounce_until toggle every 2 cycles starting high.
  // rst_cycle: reset is held high across that cycle's edge only.
  task automatic run_case(input string tag, input logic [3:0] mask, input int bounce_until,
                          input int n, input logic [127:0] exp_map, input int rst_cycle);
    logic [3:0] b;
    for (int k = 1; k <= n; k++) begin
      b = (k <= bounce_until && ((k - 1) / 2) % 2 == 1) ? 4'b0000 : mask;
      set_btn(b);
      if (k == rst_cycle) begin
        reset = 1'b1;
        #1 check($sformatf("%s rst_now", tag), {28'd0, outs()}, 32'd0);
      end
      @(posedge clk);
      #1 check($sformatf("%s c%0d", tag, k), {28'd0, outs()},
               {28'd0, (exp_map[k] ? mask : 4'b0000)});
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  logic [127:0] m;

  initial begin
    reset = 1'b1;
    set_btn(4'b0000);
    #1 check("reset_outs", {28'd0, outs()}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    m = '0; m[7] = 1'b1;
    run_case("right_held", 4'b0010, 0, 12, m, 0);

    do_reset();
    m = '0; m[35] = 1'b1;
    run_case("up_bounce", 4'b0100, 30, 45, m, 0);

    do_reset();
    m = '0; m[7] = 1'b1;
`ifdef AUTO_REPEAT_EN
    m[27] = 1'b1; m[35] = 1'b1; m[43] = 1'b1; m[51] = 1'b1; m[59] = 1'b1;
`endif
    run_case("down_held", 4'b1000, 0, 60, m, 0);
    m = '0;
    run_case("down_release", 4'b0000, 0, 12, m, 0);
    m = '0; m[7] = 1'b1;
    run_case("down_repress", 4'b1000, 0, 10, m, 0);

    do_reset();
    m = '0; m[7] = 1'b1;
    run_case("left_right", 4'b0011, 0, 12, m, 0);

    do_reset();
    m = '0; m[7] = 1'b1; m[37] = 1'b1;
`ifdef AUTO_REPEAT_EN
    m[27] = 1'b1; m[57] = 1'b1;
`endif
    run_case("down_rst30", 4'b1000, 0, 60, m, 30);

    do_reset();
    m = '0; m[7] = 1'b1;
    run_case("left_pre", 4'b0001, 0, 7, m, 0);
    check("mid_pulse_high", {28'd0, outs()}, 32'd1);
    reset = 1'b1;
    #1 check("mid_pulse_rst", {28'd0, outs()}, 32'd0);
    @(posedge clk);
    #1 check("rst_hold", {28'd0, outs()}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_case("left_after_rst", 4'b0001, 0, 9, m, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/panel_buttons.md
PANEL_BUTTONS -- requirements
Module: panel_buttons

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable synchronized samples needed to accept a level change (20 ms at 25 MHz); legal range 1..2^24-1.
REQ-002 SHALL have parameter REPEAT_DELAY, default 12500000, cycles from the press pulse to the first auto-repeat pulse; legal range 1..2^24-1.
REQ-003 SHALL have parameter REPEAT_RATE, default 2500000, cycles between later auto-repeat pulses; legal range 1..2^24-1.
REQ-004 SHALL have port clk, input, 1, the single pixel clock that also drives the panel renderer.
REQ-005 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have ports btn_left, btn_right, btn_up and btn_down, each input, 1, raw active-high board buttons, asynchronous to clk and bouncing.
REQ-007 SHALL have ports left, right, up and down, each output, 1, registered single-cycle navigation pulses for the front panel.

Function
REQ-008 Each button SHALL own an independent channel: a 2-FF synchronizer, a debounce counter, a debounced level and a pulse FSM. Channels share no state.
REQ-009 Debounce: on every cycle where the synchronized sample differs from the debounced level, the counter SHALL increment. On any cycle where they match, the counter SHALL clear.
REQ-010 When the counter reaches DEBOUNCE_CYCLES, the debounced level SHALL toggle and the counter SHALL clear in the same edge. A bounce shorter than DEBOUNCE_CYCLES therefore causes no change.
REQ-011 FSM states SHALL be IDLE, HELD and REPEAT.
  - IDLE -> HELD on a debounced 0->1 edge.
  - HELD -> REPEAT when the repeat counter expires.
  - REPEAT -> REPEAT each time the repeat counter expires.
  - Any state -> IDLE when the debounced level is 0.
REQ-012 On entering HELD, the FSM SHALL emit one output pulse and load the repeat counter with REPEAT_DELAY-1.
REQ-013 On each expiry (counter==0 while in HELD or REPEAT), the FSM SHALL emit one output pulse and reload REPEAT_RATE-1.
REQ-014 Latency: with raw input held steady high, the first pulse SHALL be asserted in cycle DEBOUNCE_CYCLES+3, counting the first edge that samples raw high as cycle 1.
REQ-015 Every output pulse SHALL be exactly one cycle wide. A release SHALL never produce a pulse.
REQ-016 Simultaneous presses on several buttons SHALL produce simultaneous pulses on each output. The block SHALL NOT arbitrate between buttons; the consumer resolves priority.
REQ-017 Release during HELD or REPEAT SHALL abort the repeat sequence with no further pulse. A re-press SHALL restart from REQ-012.
REQ-018 Counters SHALL be sized $clog2(param+1) and SHALL saturate rather than wrap.

Reset
REQ-019 While reset is high, all outputs SHALL be 0.
REQ-020 While reset is high, synchronizer flops, debounced levels and counters SHALL be 0, and every FSM SHALL be in IDLE; this takes effect immediately, not at a clock edge.
REQ-021 A button already held when reset deasserts SHALL be treated as a new press: it is debounced per REQ-014 and emits one pulse.
REQ-022 Reset asserted mid-pulse or mid-repeat SHALL clear the output at once. No pulse SHALL be emitted on the reset edge or on the deassertion edge.

Configuration
REQ-023 Macro AUTO_REPEAT_EN defined: the full IDLE/HELD/REPEAT behaviour of REQ-011..REQ-013 SHALL apply.
REQ-024 Macro AUTO_REPEAT_EN undefined:
  - REPEAT state and repeat counters SHALL be compiled out.
  - HELD SHALL persist until release.
  - Exactly one pulse SHALL be emitted per debounced press.
  - REPEAT_DELAY and REPEAT_RATE SHALL be ignored.

Verification
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
REQ-025 btn_right held high from cycle 1 -> right pulses high for exactly cycle 7; left, up and down stay 0.
REQ-026 btn_up toggles every 2 cycles for 30 cycles, then is held high -> no pulse during the bounce; exactly one up pulse 7 cycles after the last rising edge.
REQ-027 With AUTO_REPEAT_EN, btn_down held for 60 cycles -> pulses at cycles 7, 27, 35, 43, 51, 59. After release, no pulse, and the FSM reaches IDLE within 7 cycles.
REQ-028 Without AUTO_REPEAT_EN, the same stimulus as REQ-027 -> a single pulse at cycle 7 only.
REQ-029 btn_left and btn_right rise on the same cycle -> left and right pulse together in cycle 7.
REQ-030 Reset asserted for 1 cycle at cycle 30 while btn_down is held (AUTO_REPEAT_EN) -> the cycle-35 pulse is not emitted. down stays 0 during reset and pulses again about 7 cycles after reset deassertion.
